noc_sync_fifo: RTL and testbench

NOC_SYNC_FIFO -- requirements
Module: noc_sync_fifo

---
 rtl/noc_sync_fifo.sv | 99 +++++++++
 tb/tb_noc_sync_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: single-clock circular-buffer FIFO with first-word-fall-through
// read data, occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
module noc_sync_fifo #(
  parameter int WIDTH    = 45,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rstp,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              writep,
  input  logic              readp,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  data_out,
  output logic              emptyp,
  output logic              fullp,
  output logic              almost_fullp,
  output logic              almost_emptyp,
  output logic [ADDR_W:0]   count,
  output logic              overflowp,
  output logic              underflowp
);

  localparam int DEPTH = 1 << ADDR_W;

  // Thresholds expressed at count width so the decodes compare like with like.
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_CNT   = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_CNT   = AE_LEVEL[ADDR_W:0];

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf_set;
  logic              unf_set;

  // Status flags decode from count alone so they never disagree with it.
  always_comb begin
    emptyp        = (count == '0);
    fullp         = (count == FULL_CNT);
    almost_fullp  = (count >= AF_CNT);
    almost_emptyp = (count <= AE_CNT);
  end

  // Accept decisions; a write into a full FIFO rides on a same-cycle pop.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch
    // is inferred.
    rd_acc  = readp & ~emptyp;
    wr_acc  = writep & (~fullp | rd_acc);
    ovf_set = writep & ~wr_acc;
    unf_set = readp & emptyp;
  end

  // Head of queue is presented with zero latency.
  assign data_out = mem[tail];

  // Storage array: written only on an accepted write.
  always_ff @(posedge clk) begin
    // NOTE: the data array carries no reset; only pointers and count define
    // which entries are valid, and leaving it unreset keeps it a plain RAM.
    if (wr_acc && !rstp) begin
      mem[head] <= data_in;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rstp) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflowp  <= 1'b0;
      underflowp <= 1'b0;
    end else begin
      if (wr_acc) head <= head + ADDR_W'(1);
      if (rd_acc) tail <= tail + ADDR_W'(1);

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A set condition in the same cycle takes priority over the clear.
      if (ovf_set)      overflowp <= 1'b1;
      else if (clr_err) overflowp <= 1'b0;

      if (unf_set)      underflowp <= 1'b1;
      else if (clr_err) underflowp <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_sync_fifo.sv
// tb_noc_sync_fifo: directed + randomised checks of noc_sync_fifo against a
// queue-based reference model.
module tb_noc_sync_fifo;

  localparam int WIDTH = 45;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rstp;
  logic [WIDTH-1:0] data_in;
  logic             writep;
  logic             readp;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             emptyp;
  logic             fullp;
  logic             almost_fullp;
  logic             almost_emptyp;
  logic [3:0]       count;
  logic             overflowp;
  logic             underflowp;

  noc_sync_fifo dut (
    .clk           (clk),
    .rstp          (rstp),
    .data_in       (data_in),
    .writep        (writep),
    .readp         (readp),
    .clr_err       (clr_err),
    .data_out      (data_out),
    .emptyp        (emptyp),
    .fullp         (fullp),
    .almost_fullp  (almost_fullp),
    .almost_emptyp (almost_emptyp),
    .count         (count),
    .overflowp     (overflowp),
    .underflowp    (underflowp)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [WIDTH-1:0] exp_q[$];
  bit               m_ovf;
  bit               m_unf;
  int               checks;
  int               errors;
  int               max_count;
  int               wr_total;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output with the model.
  task automatic check_state(input string tag);
    int n;
    n = exp_q.size();
    check({tag, " count"},  64'(count), 64'(n));
    check({tag, " empty"},  64'(emptyp), 64'(n == 0));
    check({tag, " full"},   64'(fullp), 64'(n == DEPTH));
    check({tag, " afull"},  64'(almost_fullp), 64'(n >= 6));
    check({tag, " aempty"}, 64'(almost_emptyp), 64'(n <= 2));
    check({tag, " ovf"},    64'(overflowp), 64'(m_ovf));
    check({tag, " unf"},    64'(underflowp), 64'(m_unf));
    if (n > 0) check({tag, " data"}, 64'(data_out), 64'(exp_q[0]));
    if (int'(count) > max_count) max_count = int'(count);
  endtask

  // One clock cycle: drive, predict, advance, then compare after the edge.
  task automatic step(input bit w, input bit r, input bit c, input bit rst,
                      input logic [WIDTH-1:0] d, input string tag);
    bit rd;
    bit wr;
    writep  = w;
    readp   = r;
    clr_err = c;
    rstp    = rst;
    data_in = d;
    rd = r && exp_q.size() > 0;
    wr = w && (exp_q.size() < DEPTH || rd);
    if (rd && !rst) check({tag, " pop"}, 64'(data_out), 64'(exp_q[0]));
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (rd) void'(exp_q.pop_front());
      if (wr) begin
        exp_q.push_back(d);
        wr_total++;
      end
      if (w && !wr)   m_ovf = 1'b1;
      else if (c)     m_ovf = 1'b0;
      if (r && !rd)   m_unf = 1'b1;
      else if (c)     m_unf = 1'b0;
    end
    writep  = 1'b0;
    readp   = 1'b0;
    clr_err = 1'b0;
    rstp    = 1'b0;
    check_state(tag);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    max_count = 0;
    wr_total  = 0;
    rstp      = 1'b1;
    writep    = 1'b0;
    readp     = 1'b0;
    clr_err   = 1'b0;
    data_in   = '0;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, "reset");
    step(1'b0, 1'b0, 1'b0, 1'b1, '0, "reset2");

    // Fill 1..8; head stays 1, almost-full from 6, full at 8.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(i), "fill");
    check("fill head", 64'(data_out), 64'd1);
    check("fill full", 64'(fullp), 64'd1);

    // Write to full is refused and sets overflow; clear drops it.
    step(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(99), "ovf");
    check("ovf flag", 64'(overflowp), 64'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, WIDTH'(98), "ovf set wins");
    check("ovf kept", 64'(overflowp), 64'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, "clr");
    check("ovf cleared", 64'(overflowp), 64'd0);

    // Simultaneous read+write on full keeps count, then drain 2..9.
    step(1'b1, 1'b1, 1'b0, 1'b0, WIDTH'(9), "full rw");
    check("full rw head", 64'(data_out), 64'd2);
    check("full rw count", 64'(count), 64'd8);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, "drain");
    check("drain empty", 64'(emptyp), 64'd1);

    // Read+write on empty: write accepted, read refused.
    step(1'b1, 1'b1, 1'b0, 1'b0, WIDTH'(10), "empty rw");
    check("empty rw data", 64'(data_out), 64'hA);
    check("empty rw unf", 64'(underflowp), 64'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, "empty rw pop");

    // Wide data pattern through the full word width.
    step(1'b1, 1'b0, 1'b0, 1'b0, {WIDTH{1'b1}}, "wide");
    step(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(45'h0AAA_5555_1234), "wide2");
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, "wide pop");
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, "wide pop2");

    // Random traffic: at least 20 further writes so the pointers wrap twice.
    wr_total = 0;
    for (int i = 0; i < 400 && wr_total < 24; i++) begin
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0), 1'b0,
           WIDTH'({$urandom, $urandom}), "rand");
    end
    check("rand writes", 64'(wr_total >= 20), 64'd1);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, "rand drain");
    check("rand max count", 64'(max_count <= DEPTH), 64'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, "rand clr");

    // Reset mid-operation with a concurrent write discards everything.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(20 + i), "pre rst");
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, "pre rst unf");
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, "pre rst unf2");
    step(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(77), "pre rst more");
    step(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(78), "pre rst more2");
    step(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(79), "pre rst more3");
    step(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(80), "pre rst ovf");
    step(1'b1, 1'b1, 1'b1, 1'b1, WIDTH'(55), "mid rst");
    check("mid rst count", 64'(count), 64'd0);
    check("mid rst empty", 64'(emptyp), 64'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, WIDTH'(5), "post rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
